// File: rtl/wfg_spi_rx.sv
// SPI peripheral-side receiver: oversamples SCLK/CS_N/SDI in the clk domain,
// deserialises 8/16/24/32-bit words and presents them on a one-deep AXI-stream register.
module wfg_spi_rx #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ctrl_en_i,
  input  logic                  ctrl_cpol_i,
  input  logic                  ctrl_cpha_i,
  input  logic                  ctrl_lsbfirst_i,
  input  logic [1:0]            ctrl_dwidth_i,
  input  logic                  clr_err_i,
  input  logic                  spi_sclk_i,
  input  logic                  spi_cs_ni,
  input  logic                  spi_sdi_i,
  output logic [DATA_WIDTH-1:0] wfg_axis_tdata_o,
  output logic                  wfg_axis_tvalid_o,
  input  logic                  wfg_axis_tready_i,
  output logic                  busy_o,
  output logic                  overflow_o,
  output logic                  frame_err_o
);

  localparam int unsigned SW = 32;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, sdi_sync;
  logic                   sclk_s, cs_s, sdi_s;
  logic                   sclk_d, cs_d;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [0:0]    state_q;
  logic [5:0]    bit_cnt_q;
  logic [SW-1:0] shift_q, shift_nxt;
  logic [5:0]    word_bits;
  logic [4:0]    bit_idx;
  logic          active, sample, word_done, frame_err_set, overflow_set;

  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q, overflow_q, frame_err_q;

  // CS_N chain resets low so a CS_N already low at reset release never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      sdi_sync  <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync[0] <= spi_sclk_i;
      cs_sync[0]   <= spi_cs_ni;
      sdi_sync[0]  <= spi_sdi_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync[i] <= sclk_sync[i-1];
        cs_sync[i]   <= cs_sync[i-1];
        sdi_sync[i]  <= sdi_sync[i-1];
      end
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  assign active    = (state_q == ST_ACTIVE);
  assign word_bits = {({1'b0, ctrl_dwidth_i} + 3'd1), 3'b000};
  assign sample    = active && ctrl_en_i && !cs_rise &&
                     ((ctrl_cpol_i == ctrl_cpha_i) ? sclk_rise : sclk_fall);
  assign bit_idx   = ctrl_lsbfirst_i ? bit_cnt_q[4:0] : 5'(word_bits - 6'd1 - bit_cnt_q);

  // Bits are placed at their final position rather than shifted, so both bit orders land right-aligned.
  always_comb begin
    shift_nxt = shift_q;
    if (sample) shift_nxt[bit_idx] = sdi_s;
  end

  assign word_done     = sample && ((bit_cnt_q + 6'd1) == word_bits);
  assign frame_err_set = active && ctrl_en_i && cs_rise && (bit_cnt_q != 6'd0);
  assign overflow_set  = word_done && tvalid_q && !wfg_axis_tready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          bit_cnt_q <= '0;
          shift_q   <= '0;
          if (ctrl_en_i && cs_fall) state_q <= ST_ACTIVE;
        end
        default: begin
          if (!ctrl_en_i || cs_rise) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
          end else if (word_done) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
          end else if (sample) begin
            bit_cnt_q <= bit_cnt_q + 6'd1;
            shift_q   <= shift_nxt;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else if (word_done && (!tvalid_q || wfg_axis_tready_i)) begin
      tdata_q  <= DATA_WIDTH'(shift_nxt);
      tvalid_q <= 1'b1;
    end else if (tvalid_q && wfg_axis_tready_i) begin
      tvalid_q <= 1'b0;
    end
  end

  // Set is evaluated after clear so a coincident new error wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (clr_err_i) begin
        overflow_q  <= 1'b0;
        frame_err_q <= 1'b0;
      end
      if (overflow_set)  overflow_q  <= 1'b1;
      if (frame_err_set) frame_err_q <= 1'b1;
    end
  end

  assign wfg_axis_tdata_o  = tdata_q;
  assign wfg_axis_tvalid_o = tvalid_q;
  assign busy_o            = active;
  assign overflow_o        = overflow_q;
  assign frame_err_o       = frame_err_q;

endmodule

// File: tb/tb_wfg_spi_rx.sv
// Scoreboard bench for wfg_spi_rx: a behavioural SPI controller drives frames,
// expected words go into a queue, and a monitor pops them on each handshake.
module tb_wfg_spi_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ctrl_en = 1'b0, ctrl_cpol = 1'b0, ctrl_cpha = 1'b0, ctrl_lsbfirst = 1'b0;
  logic [1:0]  ctrl_dwidth = 2'b00;
  logic        clr_err = 1'b0;
  logic        spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_sdi = 1'b0;
  logic [31:0] tdata;
  logic        tvalid, tready = 1'b0;
  logic        busy, overflow, frame_err;
  logic        rand_rdy = 1'b0;

  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  wfg_spi_rx #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ctrl_en_i         (ctrl_en),
    .ctrl_cpol_i       (ctrl_cpol),
    .ctrl_cpha_i       (ctrl_cpha),
    .ctrl_lsbfirst_i   (ctrl_lsbfirst),
    .ctrl_dwidth_i     (ctrl_dwidth),
    .clr_err_i         (clr_err),
    .spi_sclk_i        (spi_sclk),
    .spi_cs_ni         (spi_cs_n),
    .spi_sdi_i         (spi_sdi),
    .wfg_axis_tdata_o  (tdata),
    .wfg_axis_tvalid_o (tvalid),
    .wfg_axis_tready_i (tready),
    .busy_o            (busy),
    .overflow_o        (overflow),
    .frame_err_o       (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && tvalid && tready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_beat: got %h expected no beat", tdata);
      end else begin
        check("beat", tdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) tready = ($urandom_range(3) != 0);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic half_bit();
    cycles(4);
  endtask

  function automatic logic [31:0] mask_of(input int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return m[31:0];
  endfunction

  task automatic set_mode(input logic [1:0] mode, input logic [1:0] dw, input logic lsb);
    ctrl_cpol     = mode[1];
    ctrl_cpha     = mode[0];
    ctrl_dwidth   = dw;
    ctrl_lsbfirst = lsb;
    spi_sclk      = mode[1];
    cycles(6);
  endtask

  task automatic spi_bit(input logic b);
    if (!ctrl_cpha) begin
      spi_sdi = b;
      half_bit();
      spi_sclk = ~ctrl_cpol;
      half_bit();
      spi_sclk = ctrl_cpol;
    end else begin
      spi_sclk = ~ctrl_cpol;
      spi_sdi  = b;
      half_bit();
      spi_sclk = ctrl_cpol;
      half_bit();
    end
  endtask

  task automatic spi_word(input logic [31:0] w, input int n, input int nsend);
    for (int i = 0; i < nsend; i++) spi_bit(ctrl_lsbfirst ? w[i] : w[n-1-i]);
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    half_bit();
  endtask

  task automatic cs_high();
    half_bit();
    spi_cs_n = 1'b1;
    half_bit();
    half_bit();
  endtask

  task automatic send_expect(input logic [31:0] w, input int n);
    exp_q.push_back(w & mask_of(n));
    spi_word(w, n, n);
  endtask

  task automatic drain(input string name);
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 2000) begin
      cycles(1);
      waited++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    cycles(1);
    clr_err = 1'b0;
  endtask

  initial begin
    int          n;
    int          nw;
    logic [1:0]  dw;
    logic [31:0] w;

    cycles(4);
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    rst_n   = 1'b1;
    ctrl_en = 1'b1;
    tready  = 1'b1;

    // Mode 0, 8-bit, MSB-first
    set_mode(2'd0, 2'b00, 1'b0);
    cs_low();
    check("t1_busy_active", busy, 1);
    send_expect(32'hA5, 8);
    cs_high();
    drain("t1_drain");
    check("t1_busy_idle", busy, 0);
    check("t1_overflow", overflow, 0);
    check("t1_frame_err", frame_err, 0);

    // Mode 3, 32-bit, two words in one frame
    set_mode(2'd3, 2'b11, 1'b0);
    cs_low();
    send_expect(32'hDEADBEEF, 32);
    send_expect(32'h12345678, 32);
    cs_high();
    drain("t2_drain");
    check("t2_errors", {overflow, frame_err}, 0);

    // Mode 1, 16-bit, LSB-first
    set_mode(2'd1, 2'b01, 1'b1);
    cs_low();
    send_expect(32'h1234, 16);
    cs_high();
    drain("t3_drain");

    // Mode 2, 24-bit, MSB-first
    set_mode(2'd2, 2'b10, 1'b0);
    cs_low();
    send_expect(32'hC0FFEE, 24);
    cs_high();
    drain("t4_drain");

    // Overflow: second word arrives while the first is still held
    set_mode(2'd0, 2'b00, 1'b0);
    tready = 1'b0;
    cs_low();
    send_expect(32'h11, 8);
    spi_word(32'h22, 8, 8);
    cs_high();
    cycles(10);
    check("t5_tvalid_held", tvalid, 1);
    check("t5_tdata_held", tdata, 32'h11);
    check("t5_overflow", overflow, 1);
    tready = 1'b1;
    cycles(1);
    tready = 1'b0;
    check("t5_tvalid_after", tvalid, 0);
    check("t5_popped", exp_q.size(), 0);
    pulse_clr();
    check("t5_overflow_clr", overflow, 0);
    tready = 1'b1;

    // CS_N abort after 5 bits, then a clean frame
    cs_low();
    spi_word(32'hFF, 8, 5);
    cs_high();
    cycles(10);
    check("t6_frame_err", frame_err, 1);
    check("t6_no_beat", tvalid, 0);
    cs_low();
    send_expect(32'h3C, 8);
    cs_high();
    drain("t6_after_abort");
    check("t6_frame_err_sticky", frame_err, 1);

    // Reset mid-frame: rest of the frame must not produce a word
    cs_low();
    spi_word(32'h5A, 8, 3);
    rst_n = 1'b0;
    cycles(3);
    check("t6r_outputs", {tdata[7:0], tvalid, busy, overflow, frame_err}, 0);
    rst_n = 1'b1;
    cycles(2);
    spi_word(32'h5A, 8, 5);
    cycles(10);
    check("t6r_no_beat", tvalid, 0);
    check("t6r_busy", busy, 0);
    cs_high();
    check("t6r_frame_err", frame_err, 0);
    cs_low();
    send_expect(32'h96, 8);
    cs_high();
    drain("t6r_recover");

    // Randomised frames: mode, size, bit order, words per frame and tready
    rand_rdy = 1'b1;
    for (int f = 0; f < 20; f++) begin
      dw = 2'($urandom_range(3));
      n  = (int'(dw) + 1) * 8;
      set_mode(2'($urandom_range(3)), dw, 1'($urandom_range(1)));
      nw = $urandom_range(1, 3);
      cs_low();
      for (int k = 0; k < nw; k++) begin
        w = $urandom;
        send_expect(w, n);
      end
      cs_high();
    end
    drain("rand_drain");
    rand_rdy = 1'b0;
    cycles(2);
    tready = 1'b1;
    check("rand_errors", {overflow, frame_err}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
